// File: rtl/lsu_mem_access_pkg.sv
// lsu_mem_access_pkg: shared encodings and helpers for the load/store unit
package lsu_mem_access_pkg;
  localparam int MEM_LANES = 8;
  localparam int LSU_DATA_W = MEM_LANES * 8;
  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;
  localparam logic [1:0] LSU_SIZE_D = 2'd3;
  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_RESP} lsu_state_e;
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] off);
    return size == LSU_SIZE_H ? off[0] :
           size == LSU_SIZE_W ? |off[1:0] :
           size == LSU_SIZE_D ? |off : 1'b0;
  endfunction
endpackage

// File: rtl/lsu_mem_access_align.sv
// lsu_align: byte-lane mask, store data shift and load extract/extend
module lsu_align
  import lsu_mem_access_pkg::*;
(
  input  logic [1:0]            size_i,
  input  logic [2:0]            off_i,
  input  logic                  uns_i,
  input  logic [LSU_DATA_W-1:0] wdata_i,
  input  logic [LSU_DATA_W-1:0] rdata_i,
  output logic [MEM_LANES-1:0]  wmask_o,
  output logic [LSU_DATA_W-1:0] wdata_o,
  output logic [LSU_DATA_W-1:0] rdata_o
);
  logic [LSU_DATA_W-1:0] sh;
  assign wmask_o = size_i == LSU_SIZE_D ? 8'hFF :
                   (size_i == LSU_SIZE_W ? 8'h0F : size_i == LSU_SIZE_H ? 8'h03 : 8'h01) << off_i;
  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign sh = rdata_i >> {off_i, 3'b000};
  assign rdata_o = size_i == LSU_SIZE_B ? {{56{~uns_i & sh[7]}}, sh[7:0]} :
                   size_i == LSU_SIZE_H ? {{48{~uns_i & sh[15]}}, sh[15:0]} :
                   size_i == LSU_SIZE_W ? {{32{~uns_i & sh[31]}}, sh[31:0]} : sh;
endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: sequences one aligned memory transaction per EXU load/store
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]        size_q, size_d;
  logic              wen_q, wen_d, uns_q, uns_d, err_q, err_d;
  logic [7:0]        wmask;
  logic [DATA_W-1:0] wdata_sh, rdata_ext;
  logic              mis;

  lsu_align u_align (
    .size_i (size_q),
    .off_i  (addr_q[2:0]),
    .uns_i  (uns_q),
    .wdata_i(wdata_q),
    .rdata_i(mem_rdata),
    .wmask_o(wmask),
    .wdata_o(wdata_sh),
    .rdata_o(rdata_ext)
  );

  assign mis        = lsu_misaligned(req_size, req_addr[2:0]);
  assign req_ready  = state_q == LSU_IDLE && !rst;
  assign resp_valid = state_q == LSU_RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_valid  = state_q == LSU_REQ;
  assign mem_wen    = mem_valid & wen_q;
  assign mem_addr   = mem_valid ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_wdata  = mem_valid ? wdata_sh : '0;
  assign mem_wmask  = mem_wen ? wmask : 8'h00;

  // next state: latch the op on accept, result captured on the memory ack
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    wen_d   = wen_q;
    uns_d   = uns_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      LSU_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        size_d  = req_size;
        wen_d   = req_wen;
        uns_d   = req_unsigned;
        state_d = mis ? LSU_RESP : LSU_REQ;
        if (mis) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      LSU_REQ:  state_d = mem_ready ? LSU_WAIT : LSU_REQ;
      LSU_WAIT: if (mem_rvalid) begin
        state_d = LSU_RESP;
        err_d   = 1'b0;
        rdata_d = wen_q ? '0 : rdata_ext;
      end
      default:  state_d = LSU_IDLE;
    endcase
  end

  // state and latched op registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_access.sv
// tb_lsu_mem_access: randomized load/store traffic against a byte-level reference model
module tb_lsu_mem_access;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_wen = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_err, mem_valid, mem_wen;
  logic [63:0] resp_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready = 0, mem_rvalid = 0;
  logic [63:0] mem_rdata = 0;
  int          vec_n = 0, miss_n = 0;

  lsu_mem_access dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_n++;
    if (got !== exp) begin
      miss_n++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input int rdy_dly, input int rv_dly);
    int nb, off;
    logic mis;
    logic [7:0] xm;
    logic [63:0] xw, xr, xa;
    nb  = 1 << size;
    off = int'(addr[2:0]);
    mis = (off % nb) != 0;
    xm  = '0;
    xr  = '0;
    for (int b = 0; b < 8; b++) if (wen && b >= off && b < off + nb) xm[b] = 1'b1;
    xw = wdata << (8 * off);
    xa = addr & ~64'h7;
    for (int k = 0; k < nb && off + k < 8; k++) xr[8*k +: 8] = rdata[8*(off+k) +: 8];
    if (!uns && nb < 8 && xr[8*nb-1]) for (int k = nb; k < 8; k++) xr[8*k +: 8] = 8'hFF;
    if (wen || mis) xr = '0;
    req_valid = 1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    chk("rdy_idle", req_ready, 1);
    tick();
    req_valid = 0; req_wen = ~wen; req_size = 2'($urandom); req_unsigned = ~uns;
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    if (mis) begin
      chk("mis_rv", resp_valid, 1);
      chk("mis_err", resp_err, 1);
      chk("mis_rd", resp_rdata, 0);
      chk("mis_mv", mem_valid, 0);
      chk("mis_rdy", req_ready, 0);
      tick();
      chk("mis_rv_end", resp_valid, 0);
      chk("mis_mv_end", mem_valid, 0);
      chk("mis_rdy_end", req_ready, 1);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("req_mv", mem_valid, 1);
      chk("req_wen", mem_wen, wen);
      chk("req_addr", mem_addr, xa);
      chk("req_mask", mem_wmask, xm);
      if (wen) chk("req_wdata", mem_wdata, xw);
      chk("req_rdy", req_ready, 0);
      chk("req_rv", resp_valid, 0);
      mem_ready  = i == rdy_dly;
      mem_rvalid = 1'($urandom);
      mem_rdata  = {$urandom, $urandom};
      tick();
    end
    mem_ready = 0;
    for (int j = 0; j <= rv_dly; j++) begin
      chk("wait_mv", mem_valid, 0);
      chk("wait_rdy", req_ready, 0);
      chk("wait_rv", resp_valid, 0);
      mem_rvalid = j == rv_dly;
      mem_rdata  = j == rv_dly ? rdata : {$urandom, $urandom};
      tick();
    end
    mem_rvalid = 0;
    mem_rdata  = {$urandom, $urandom};
    chk("resp_rv", resp_valid, 1);
    chk("resp_err", resp_err, 0);
    chk("resp_rd", resp_rdata, xr);
    chk("resp_rdy", req_ready, 0);
    tick();
    chk("post_rv", resp_valid, 0);
    chk("post_rdy", req_ready, 1);
    chk("post_rd_hold", resp_rdata, xr);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_rdy", req_ready, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_rd", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_mv", mem_valid, 0);
    chk("rst_mask", mem_wmask, 0);
    chk("rst_maddr", mem_addr, 0);
    rst = 0;
    #1;
    chk("idle_rdy", req_ready, 1);
    run_op(1, 3, 0, 64'h80000008, 64'h1122334455667788, 64'h0, 0, 0);
    run_op(0, 2, 0, 64'h80000004, 64'h0, 64'h80000000_00000000, 0, 0);
    chk("ld_w_s_lit", resp_rdata, 64'hFFFFFFFF80000000);
    run_op(0, 2, 1, 64'h80000004, 64'h0, 64'h80000000_00000000, 0, 0);
    chk("ld_w_u_lit", resp_rdata, 64'h0000000080000000);
    run_op(1, 0, 0, 64'h80000003, 64'hAB, 64'h0, 0, 0);
    run_op(0, 1, 0, 64'h80000001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_op(1, 3, 0, 64'h80000010, 64'hDEADBEEFCAFEF00D, 64'h0, 3, 2);
    // reset while waiting for the memory response
    req_valid = 1; req_wen = 0; req_size = 3; req_unsigned = 0; req_addr = 64'h80000020;
    tick();
    req_valid = 0;
    mem_ready = 1;
    tick();
    mem_ready = 0;
    chk("rw_mv", mem_valid, 0);
    rst = 1;
    #1;
    chk("rw_rdy_rst", req_ready, 0);
    tick();
    rst = 0;
    #1;
    chk("rw_rv", resp_valid, 0);
    chk("rw_mv2", mem_valid, 0);
    chk("rw_rdy", req_ready, 1);
    chk("rw_rd", resp_rdata, 0);
    mem_rvalid = 1;
    mem_rdata = 64'h1234;
    tick();
    mem_rvalid = 0;
    chk("rw_late_rv", resp_valid, 0);
    chk("rw_late_rdy", req_ready, 1);
    tick();
    chk("rw_late_rv2", resp_valid, 0);
    run_op(0, 3, 0, 64'h80000028, 64'h0, 64'h0123456789ABCDEF, 1, 1);
    for (int n = 0; n < 200; n++)
      run_op(1'($urandom), 2'($urandom), 1'($urandom), {32'h0, 32'h80000000 | $urandom_range(0, 255)},
             {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3));
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end
endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Executes loads and stores that the instruction decoder requests through its store flag, write mask and sign-extension controls.
- Sits between EXU (request side, address from ALU) and the data-memory port (DPI pmem wrapper or bus bridge).
- Generates the byte-lane write mask and shifted write data, and sequences one memory transaction per request with a valid/ready handshake.
- Returns load data aligned and sign/zero-extended for writeback.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; 8 byte lanes are fixed, so DATA_W must be 64

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  EXU presents a memory op
- req_ready  out  1  LSU can accept an op
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- req_unsigned  in  1  load zero-extends when set
- req_addr  in  ADDR_W  effective byte address
- req_wdata  in  DATA_W  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data; 0 for stores
- resp_err  out  1  misaligned access, no memory traffic issued
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts the request
- mem_wen  out  1  write request
- mem_addr  out  ADDR_W  req_addr with bits [2:0] = 0
- mem_wdata  out  DATA_W  req_wdata << (8*addr[2:0])
- mem_wmask  out  8  byte-lane enables; 0 for loads
- mem_rvalid  in  1  read data valid, or write acknowledge
- mem_rdata  in  DATA_W  raw 8-byte-aligned read data

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- States: IDLE, REQ, WAIT, RESP.
- Reset values: state = IDLE; req_ready = 0 while rst is high, otherwise 1 in IDLE; mem_valid = 0; resp_valid = 0; resp_rdata = 0; resp_err = 0; all mem_* outputs = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the op (addr, size, wen, unsigned, wdata).
  - If misaligned, go to RESP with the error flag set. Misaligned means size 1 with addr[0] != 0, size 2 with addr[1:0] != 0, or size 3 with addr[2:0] != 0.
  - Otherwise go to REQ.
- REQ:
  - mem_valid = 1, with mem_* driven from latched values.
  - mem_valid and all mem_* stay stable until mem_ready.
  - On mem_valid & mem_ready, go to WAIT.
- WAIT:
  - mem_valid = 0.
  - mem_rvalid is sampled only in WAIT; an mem_rvalid seen in REQ is ignored.
  - On mem_rvalid, capture the extended data (loads) and go to RESP.
  - No timeout.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_rdata and resp_err hold until the next RESP.
- req_ready = 0 in REQ, WAIT and RESP; a new request can be accepted in the cycle after RESP.
- Minimum latency: accept at cycle 0, REQ at 1 (mem_ready = 1), WAIT at 2 (mem_rvalid = 1), resp_valid at 3. Misaligned: resp_valid at cycle 1.
- Write mask by size, with off = addr[2:0]:
  - byte: 8'h01 << off
  - half: 8'h03 << off
  - word: 8'h0F << off
  - dword: 8'hFF
- Load extract: sh = mem_rdata >> (8*off), then truncate to the access size and extend.
  - Sign-extend from bit 7/15/31 unless req_unsigned.
  - dword ignores req_unsigned.
- Stores: resp_rdata = 0; mem_rvalid acts as the write ack and its rdata is ignored.
- A reset asserted in any state returns to IDLE at that edge. mem_valid drops, and no resp_valid is produced for the aborted op.
- req_valid asserted while req_ready = 0 is ignored. EXU holds it until the handshake.

Decomposition:
- Shared defines header gets these, beside the existing ALU/IMM opcodes:
  - LSU_SIZE_B/H/W/D encodings
  - LSU state encodings
  - MEM_LANES = 8
- Sub-module lsu_align (combinational):
  - inputs: size, off, unsigned, wdata, rdata
  - outputs: wmask, shifted wdata, extended rdata
- Only lsu_align is tested standalone.

Test Plan:
- Store dword: addr=0x80000008, wdata=0x1122334455667788, size=3, mem_ready and mem_rvalid immediate -> mem_addr=0x80000008, wmask=0xFF, mem_wdata unchanged, resp_valid at cycle 3, resp_rdata=0.
- Load word signed: addr=0x80000004, size=2, mem_rdata=0x80000000_00000000 -> resp_rdata=0xFFFFFFFF80000000. Same access with unsigned=1 -> 0x0000000080000000.
- Store byte: addr=0x80000003, wdata=0xAB, size=0 -> mem_addr=0x80000000, wmask=0x08, mem_wdata=0x00000000AB000000.
- Misaligned: half load at 0x80000001 -> no mem_valid ever, resp_valid at cycle 1, resp_err=1, resp_rdata=0.
- Backpressure: mem_ready low 3 cycles, then mem_rvalid 2 cycles later -> mem_* stable through the stall, single resp_valid pulse, req_ready low throughout.
- Reset mid-WAIT: rst=1 for 1 cycle -> state IDLE, no resp_valid. A later mem_rvalid is ignored, and the next request completes normally.
